// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined N-input adder tree with valid/ready flow control and optional running accumulation
module adder_tree_pipe #(
  parameter int N_IN   = 4,
  parameter int IN_W   = 16,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data
);
  localparam int LVL = $clog2(N_IN);
  localparam int TREE_W = IN_W + LVL;
  logic adv;
  logic [LVL-1:0] vld, tag;
  logic [ACC_W-1:0] sum_ext;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  for (genvar l = 0; l <= LVL; l++) begin : lv
    localparam int M = N_IN >> l;
    logic [M*TREE_W-1:0] n;
    if (l == 0) begin : g
      always_comb begin
        n = '0;
        for (int k = 0; k < M; k++)
          n[k*TREE_W +: TREE_W] = SIGNED != 0 ? TREE_W'($signed(in_data[k*IN_W +: IN_W]))
                                              : TREE_W'(in_data[k*IN_W +: IN_W]);
      end
    end else begin : g
      always_ff @(posedge clk)
        if (!rst_n) n <= '0;
        else if (adv)
          for (int k = 0; k < M; k++)
            n[k*TREE_W +: TREE_W] <= lv[l-1].n[2*k*TREE_W +: TREE_W] + lv[l-1].n[(2*k+1)*TREE_W +: TREE_W];
    end
  end
  assign sum_ext = SIGNED != 0 ? ACC_W'($signed(lv[LVL].n)) : ACC_W'(lv[LVL].n);
  always_ff @(posedge clk)
    if (!rst_n) begin
      vld <= '0;
      tag <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (adv) begin
      vld <= (vld << 1) | LVL'(in_valid);
      tag <= (tag << 1) | LVL'(in_acc);
      out_valid <= vld[LVL-1];
      if (vld[LVL-1]) out_data <= (tag[LVL-1] ? out_data : '0) + sum_ext;
    end
endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe: directed vector bench for adder_tree_pipe, unsigned and signed instances side by side
module tb_adder_tree_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, in_acc = 0, out_ready = 1;
  logic [63:0] in_data = '0;
  logic ir0, ov0, ir1, ov1;
  logic [23:0] od0, od1;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  adder_tree_pipe #(.N_IN(4), .IN_W(16), .SIGNED(0), .ACC_W(24)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_acc(in_acc), .out_valid(ov0), .out_ready(out_ready), .out_data(od0));
  adder_tree_pipe #(.N_IN(4), .IN_W(16), .SIGNED(1), .ACC_W(24)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_acc(in_acc), .out_valid(ov1), .out_ready(out_ready), .out_data(od1));

  typedef struct {
    logic [63:0] d;
    logic        acc;
    logic [23:0] eu;
    logic [23:0] es;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, recv, cnt;
    logic stall, took;
    logic [23:0] prev, model;
    logic [0:39] pat;
    tbl[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 24'd10, 24'd10};
    tbl[1] = '{{4{16'hFFFF}}, 1'b0, 24'h03FFFC, 24'hFFFFFC};
    tbl[2] = '{{16'h0001, 16'hFFFF, 16'h8000, 16'h8000}, 1'b0, 24'h020000, 24'hFF0000};
    tbl[3] = '{{4{16'd1}}, 1'b0, 24'd4, 24'd4};
    tbl[4] = '{{4{16'd2}}, 1'b1, 24'd12, 24'd12};
    tbl[5] = '{{4{16'hFFFF}}, 1'b1, 24'h040008, 24'd8};
    pat = 40'b1011_0000_0110_1011_1001_1111_0101_1111_1111_1111;

    step();
    chk("rst_valid", {ov1, ov0}, 2'b00);
    chk("rst_data", od0, 0);
    chk("rst_data_s", od1, 0);
    rst_n = 1;
    chk("rst_in_ready", {ir1, ir0}, 2'b11);

    // one isolated beat per vector; checks exact latency and single-cycle pulse
    for (int i = 0; i < 6; i++) begin
      in_data = tbl[i].d; in_acc = tbl[i].acc; in_valid = 1;
      step();
      in_valid = 0;
      step();
      chk("vec_early", ov0, 0);
      step();
      chk("vec_valid", {ov1, ov0}, 2'b11);
      chk("vec_u", od0, tbl[i].eu);
      chk("vec_s", od1, tbl[i].es);
      step();
      chk("vec_pulse", ov0, 0);
    end

    for (int e = 1; e <= 11; e++) begin
      in_valid = e <= 8; in_data = {4{16'hFFFF}}; in_acc = 0;
      step();
      chk("stream_valid", ov0, e >= 3 && e <= 10);
      if (ov0) chk("stream_data", od0, 24'h03FFFC);
    end
    in_valid = 0;

    rst_n = 0; step(); rst_n = 1;
    cnt = 0; model = 0;
    for (int c = 0; c < 70; c++) begin
      in_valid = c < 65; in_data = {4{16'hFFFF}}; in_acc = 1;
      step();
      if (ov0) begin
        cnt++;
        model = model + 24'h03FFFC;
        chk("wrap_run", od0, model);
        if (cnt == 64) chk("wrap_64", od0, 24'hFFFF00);
        if (cnt == 65) chk("wrap_65", od0, 24'h03FEFC);
      end
    end
    chk("wrap_count", cnt, 65);
    in_valid = 0;

    sent = 0; recv = 0;
    for (int c = 0; c < 80 && recv < 10; c++) begin
      in_valid = sent < 10; in_data = {4{16'(sent + 1)}}; in_acc = 0;
      out_ready = c < 40 ? pat[c] : 1'b1;
      #1;
      if (ov0 && !out_ready) chk("bp_in_ready", ir0, 0);
      if (ov0 && out_ready) begin
        chk("bp_data", od0, 4 * (recv + 1));
        recv++;
      end
      stall = ov0 && !out_ready;
      prev = od0;
      took = in_valid && ir0;
      step();
      if (took) sent++;
      if (stall) begin
        chk("bp_hold_valid", ov0, 1);
        chk("bp_hold_data", od0, prev);
      end
    end
    chk("bp_count", recv, 10);
    in_valid = 0; out_ready = 1;
    repeat (3) step();

    in_data = {4{16'd25}}; in_acc = 0; in_valid = 1;
    step();
    in_valid = 0;
    step(); step();
    chk("mid_base", od0, 100);
    step();
    in_data = {4{16'd7}}; in_acc = 1; in_valid = 1;
    step(); step();
    in_valid = 0; rst_n = 0;
    step();
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_data", od0, 0);
    chk("mid_rst_ready", ir0, 1);
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_no_ghost", {ov1, ov0}, 2'b00);
    end
    in_data = {48'd0, 16'd5}; in_acc = 1; in_valid = 1;
    step();
    in_valid = 0;
    step(); step();
    chk("mid_after_valid", ov0, 1);
    chk("mid_after_u", od0, 5);
    chk("mid_after_s", od1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
